// File: rtl/crtc_pixel_serializer_pkg.sv
// Shared widths, fetch-phase constants and the sideband bundle for the
// MC6845 downstream pixel serializer.
package crtc_pkg;

  localparam int DEF_CHAR_W = 8;
  localparam int DEF_MA_W   = 14;
  localparam int DEF_RA_W   = 5;
  localparam int DEF_CODE_W = 8;

  // dot_cnt values whose closing edge performs each pipeline step
  localparam int PH_SAMPLE  = 1;
  localparam int PH_RD_END  = 2;
  localparam int PH_FONT    = 3;
  localparam int PH_PATTERN = 5;

  typedef struct packed {
    logic de;
    logic hsync;
    logic vsync;
    logic cursor;
  } sideband_t;

  function automatic sideband_t sideband_none();
    sideband_t v;
    v = '{de: 1'b0, hsync: 1'b0, vsync: 1'b0, cursor: 1'b0};
    return v;
  endfunction

endpackage

// File: rtl/crtc_pixel_serializer_if.sv
// CRTC sample, memory-fetch and monitor-side signals of the pixel serializer.
// master is the serializer, slave is the CRTC/RAM/ROM/monitor environment.
interface crtc_pixel_serializer_if #(
  parameter int MA_W   = crtc_pkg::DEF_MA_W,
  parameter int RA_W   = crtc_pkg::DEF_RA_W,
  parameter int CODE_W = crtc_pkg::DEF_CODE_W,
  parameter int CHAR_W = crtc_pkg::DEF_CHAR_W
);

  logic [MA_W-1:0]        MA;
  logic [RA_W-1:0]        RA;
  logic                   DE;
  logic                   HSYNC;
  logic                   VSYNC;
  logic                   CURSOR;
  logic                   CCLK;
  logic [MA_W-1:0]        VRAM_ADDR;
  logic                   VRAM_RD;
  logic [CODE_W-1:0]      VRAM_DATA;
  logic [CODE_W+RA_W-1:0] FONT_ADDR;
  logic [CHAR_W-1:0]      FONT_DATA;
  logic                   PIXEL;
  logic                   DE_OUT;
  logic                   HSYNC_OUT;
  logic                   VSYNC_OUT;

  modport master (
    input  MA, RA, DE, HSYNC, VSYNC, CURSOR, VRAM_DATA, FONT_DATA,
    output CCLK, VRAM_ADDR, VRAM_RD, FONT_ADDR, PIXEL, DE_OUT, HSYNC_OUT, VSYNC_OUT
  );

  modport slave (
    output MA, RA, DE, HSYNC, VSYNC, CURSOR, VRAM_DATA, FONT_DATA,
    input  CCLK, VRAM_ADDR, VRAM_RD, FONT_ADDR, PIXEL, DE_OUT, HSYNC_OUT, VSYNC_OUT
  );

endinterface

// File: rtl/crtc_pixel_serializer_dot_timer.sv
// Dot counter for one character cell: derives CCLK and one-hot strobes that
// are high during the dot_cnt value whose closing edge runs each fetch step.
module crtc_dot_timer
  import crtc_pkg::*;
#(
  parameter int CHAR_W = DEF_CHAR_W
) (
  input  logic CLK,
  input  logic RSTn,
  output logic o_cclk,
  output logic o_e_sample,
  output logic o_e_rd_end,
  output logic o_e_font,
  output logic o_e_pattern,
  output logic o_e_load
);

  localparam int               CNT_W = $clog2(CHAR_W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CHAR_W - 1);
  localparam logic [CNT_W-1:0] HALF  = CNT_W'(CHAR_W / 2);

  logic [CNT_W-1:0] r_dot_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Next dot count, wrapping by compare rather than overflow
  always_comb begin
    w_cnt_nxt = '0;
    if (r_dot_cnt == LAST) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_dot_cnt + CNT_W'(1);
    end
  end

  // Counter, CCLK and strobes all decode the next count so they stay registered
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_dot_cnt   <= '0;
      o_cclk      <= 1'b0;
      o_e_sample  <= 1'b0;
      o_e_rd_end  <= 1'b0;
      o_e_font    <= 1'b0;
      o_e_pattern <= 1'b0;
      o_e_load    <= 1'b0;
    end else begin
      r_dot_cnt   <= w_cnt_nxt;
      o_cclk      <= (w_cnt_nxt >= HALF);
      o_e_sample  <= (w_cnt_nxt == CNT_W'(PH_SAMPLE));
      o_e_rd_end  <= (w_cnt_nxt == CNT_W'(PH_RD_END));
      o_e_font    <= (w_cnt_nxt == CNT_W'(PH_FONT));
      o_e_pattern <= (w_cnt_nxt == CNT_W'(PH_PATTERN));
      o_e_load    <= (w_cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/crtc_pixel_serializer.sv
// MC6845 downstream stage: samples the CRTC once per character, fetches code
// and glyph row, and shifts the row out one dot per CLK with re-timed sidebands.
module crtc_pixel_serializer
  import crtc_pkg::*;
#(
  parameter int CHAR_W = DEF_CHAR_W,
  parameter int MA_W   = DEF_MA_W,
  parameter int RA_W   = DEF_RA_W,
  parameter int CODE_W = DEF_CODE_W
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  crtc_pixel_serializer_if.master bus
);

  logic w_cclk;
  logic w_e_sample;
  logic w_e_rd_end;
  logic w_e_font;
  logic w_e_pattern;
  logic w_e_load;

  crtc_dot_timer #(.CHAR_W(CHAR_W)) u_timer (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .o_cclk      (w_cclk),
    .o_e_sample  (w_e_sample),
    .o_e_rd_end  (w_e_rd_end),
    .o_e_font    (w_e_font),
    .o_e_pattern (w_e_pattern),
    .o_e_load    (w_e_load)
  );

  sideband_t              r_sb;
  sideband_t              r_sb_out;
  logic [RA_W-1:0]        r_ra;
  logic [MA_W-1:0]        r_vaddr;
  logic                   r_vrd;
  logic [CODE_W+RA_W-1:0] r_faddr;
  logic [CHAR_W-1:0]      r_pattern;
  logic [CHAR_W-1:0]      r_shift;

  // CRTC sample and the VRAM / font ROM fetch pipeline
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_sb      <= sideband_none();
      r_ra      <= '0;
      r_vaddr   <= '0;
      r_vrd     <= 1'b0;
      r_faddr   <= '0;
      r_pattern <= '0;
    end else begin
      if (w_e_sample) begin
        r_sb    <= '{de: bus.DE, hsync: bus.HSYNC, vsync: bus.VSYNC, cursor: bus.CURSOR};
        r_ra    <= bus.RA;
        r_vaddr <= bus.MA;
        r_vrd   <= 1'b1;
      end else if (w_e_rd_end) begin
        r_vrd   <= 1'b0;
      end
      if (w_e_font) begin
        r_faddr <= {bus.VRAM_DATA, r_ra};
      end
      if (w_e_pattern) begin
        r_pattern <= bus.FONT_DATA;
      end
    end
  end

  // Load edge commits row and sidebands together; blanking wins over cursor
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_shift  <= '0;
      r_sb_out <= sideband_none();
    end else if (w_e_load) begin
      r_shift  <= r_sb.de ? (r_pattern ^ {CHAR_W{r_sb.cursor}}) : '0;
      r_sb_out <= r_sb;
    end else begin
      r_shift  <= {r_shift[CHAR_W-2:0], 1'b0};
    end
  end

  assign bus.CCLK      = w_cclk;
  assign bus.VRAM_ADDR = r_vaddr;
  assign bus.VRAM_RD   = r_vrd;
  assign bus.FONT_ADDR = r_faddr;
  assign bus.PIXEL     = r_shift[CHAR_W-1];
  assign bus.DE_OUT    = r_sb_out.de;
  assign bus.HSYNC_OUT = r_sb_out.hsync;
  assign bus.VSYNC_OUT = r_sb_out.vsync;

  // Cursor only matters when it reaches the output row
  logic w_unused;
  assign w_unused = r_sb_out.cursor;

endmodule
